fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Sequences the shared radix-2 butterfly datapath through an in-place DIT FFT of configurable size.
- Per stage, issues one butterfly operand pair and one twiddle index per handshake, then waits until all write-backs drain before starting the next stage.
- Sits between top_control's start/size interface and the butterfly/memory datapath; produces busy/fft_done.

Parameters:
- MAX_LOG2, 5, log2 of largest supported FFT (32 points)
- SIZE_WIDTH, 11, width of fft_size
- ADDR_WIDTH, MAX_LOG2, sample address width
- TW_WIDTH, MAX_LOG2-1, twiddle index width (table of MAX_N/2 entries)
- OUT_WIDTH, MAX_LOG2, outstanding-butterfly counter width (holds 0..MAX_N/2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fft_start  in  1  start request, sampled in IDLE only
- fft_size  in  SIZE_WIDTH  point count N, latched on accepted start
- busy  out  1  transform in progress
- size_err  out  1  one-cycle pulse: start rejected for illegal N
- bf_valid  out  1  butterfly request valid
- bf_ready  in  1  datapath accepts request
- bf_addr_a  out  ADDR_WIDTH  upper-leg sample address
- bf_addr_b  out  ADDR_WIDTH  lower-leg sample address
- bf_tw_idx  out  TW_WIDTH  twiddle index, in units of W_MAX_N
- bf_stage  out  4  current stage number
- wb_valid  in  1  one butterfly result written back
- fft_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; outstanding count 0. Reset mid-transform abandons it and returns to IDLE at the same edge.
- Legal N: power of two, 2 <= N <= 2^MAX_LOG2. L = log2(N).
- Illegal N with fft_start in IDLE: size_err=1 next cycle; remain IDLE.
- States:
  - IDLE: legal start at cycle T moves to ISSUE; busy=1 and bf_valid=1 at T+1 with stage 0, k=0.
  - ISSUE: k counts 0..N/2-1. half=1<<s; j=k&(half-1); a=((k>>s)<<(s+1))+j; b=a+half; tw=j<<(MAX_LOG2-1-s).
    - bf_valid && !bf_ready: hold all bf_* outputs stable.
    - When k=N/2-1 is accepted: bf_valid=0 next cycle; go to DRAIN.
  - DRAIN: wait for outstanding==0.
    - If s<L-1: s++, k=0, re-enter ISSUE on the next cycle.
    - Else: go to DONE.
  - DONE: fft_done=1 and busy=0 for one cycle; return to IDLE.
- fft_start while busy: ignored.
- Outstanding counter:
  - +1 on bf_valid&&bf_ready; -1 on wb_valid; both in the same cycle leave it unchanged.
  - wb_valid with count 0: ignored, count stays 0.
- N=2: single stage, single butterfly (a=0, b=1, tw=0).

Optional Feature:
- Macro FFT_SEQ_STALL_CNT_EN.
- Defined: adds output stall_cycles[15:0]. It counts cycles with (bf_valid && !bf_ready) or state==DRAIN, saturates at 16'hFFFF, clears on an accepted start, and resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- fft_seq_pkg: state encoding (IDLE, ISSUE, DRAIN, DONE), MAX_N, and a log2/power-of-two check constant function.
- One sub-module, fft_bf_addr_gen: registered computation of a, b and tw from (s, k, MAX_LOG2) with hold-on-stall enable.

Test Plan:
- N=32, bf_ready=1, wb_valid returned 3 cycles after each accept:
  - 80 issues across stages 0..4.
  - Stage 1, k=1 -> a=1, b=3, tw=8.
  - Stage 4, k=5 -> a=5, b=21, tw=5.
  - Exactly one fft_done pulse; busy low in that cycle.
- N=8 (MAX_LOG2=5):
  - Stage 2, k=3 -> a=3, b=7, tw=12.
  - 12 issues total, then fft_done.
- Random bf_ready stalls:
  - bf_* stable while stalled.
  - Next stage's first issue only after the last wb_valid of the previous stage.
  - Simultaneous accept+wb_valid keeps count unchanged.
- fft_size=24, then fft_size=64 -> size_err pulse each time, busy stays 0, no bf_valid.
- Reset asserted mid-stage 2 of N=32 -> next cycle all outputs 0; a subsequent start restarts at stage 0, k=0.
- With FFT_SEQ_STALL_CNT_EN, bf_ready low for 5 cycles once, no other stalls -> stall_cycles = 5 + total DRAIN cycles.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared state encoding and size helpers for the FFT stage sequencer
package fft_seq_pkg;

    localparam int MAX_LOG2_DEF = 5;
    localparam int MAX_N        = 1 << MAX_LOG2_DEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // Index of the highest set bit; for a power of two this is log2(n).
    function automatic int size_log2(input logic [31:0] n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (n[i]) r = i;
        end
        return r;
    endfunction

    // A transform size is usable when it is a power of two in 2..2^max_log2.
    function automatic logic size_legal(input logic [31:0] n, input int max_log2);
        return (n >= 32'd2) && ((n & (n - 32'd1)) == 32'd0) && (n <= (32'd1 << max_log2));
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - butterfly request / write-back handshake between sequencer and datapath
interface fft_stage_sequencer_if
    import fft_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = MAX_LOG2_DEF,
    parameter int TW_WIDTH   = MAX_LOG2_DEF - 1
);
    logic                  bf_valid;
    logic                  bf_ready;
    logic [ADDR_WIDTH-1:0] bf_addr_a;
    logic [ADDR_WIDTH-1:0] bf_addr_b;
    logic [TW_WIDTH-1:0]   bf_tw_idx;
    logic [3:0]            bf_stage;
    logic                  wb_valid;

    modport master (
        output bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage,
        input  bf_ready, wb_valid
    );

    modport slave (
        input  bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage,
        output bf_ready, wb_valid
    );
endinterface

// File: rtl/fft_bf_addr_gen.sv
// rtl/fft_bf_addr_gen.sv - registered butterfly leg addresses and twiddle index for (stage, k)
module fft_bf_addr_gen
    import fft_seq_pkg::*;
#(
    parameter int MAX_LOG2   = 5,
    parameter int ADDR_WIDTH = MAX_LOG2,
    parameter int TW_WIDTH   = MAX_LOG2 - 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [3:0]            s,
    input  logic [TW_WIDTH-1:0]   k,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [TW_WIDTH-1:0]   tw_idx
);
    logic [ADDR_WIDTH-1:0] k_ext;
    logic [ADDR_WIDTH-1:0] half;
    logic [ADDR_WIDTH-1:0] j;
    logic [ADDR_WIDTH-1:0] a_nxt;
    logic [3:0]            tw_sh;

    // Split k into group (upper bits) and offset j within the group, then re-insert a zero at bit s.
    always_comb begin
        k_ext = ADDR_WIDTH'(k);
        half  = ADDR_WIDTH'(1) << s;
        j     = k_ext & (half - ADDR_WIDTH'(1));
        a_nxt = ((k_ext >> s) << (s + 4'd1)) | j;
        tw_sh = 4'(MAX_LOG2 - 1) - s;
    end

    // Outputs only move when a new request is loaded, so they hold while the datapath stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_a <= '0;
            addr_b <= '0;
            tw_idx <= '0;
        end else if (en) begin
            addr_a <= a_nxt;
            addr_b <= a_nxt + half;
            tw_idx <= TW_WIDTH'(j << tw_sh);
        end
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - in-place DIT FFT stage sequencer; FFT_SEQ_STALL_CNT_EN adds stall_cycles
module fft_stage_sequencer
    import fft_seq_pkg::*;
#(
    parameter int MAX_LOG2   = 5,
    parameter int SIZE_WIDTH = 11,
    parameter int ADDR_WIDTH = MAX_LOG2,
    parameter int TW_WIDTH   = MAX_LOG2 - 1,
    parameter int OUT_WIDTH  = MAX_LOG2
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fft_start,
    input  logic [SIZE_WIDTH-1:0] fft_size,
    output logic                  busy,
    output logic                  size_err,
    output logic                  fft_done,
    fft_stage_sequencer_if.master bf
`ifdef FFT_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);
    seq_state_t             state;
    logic [3:0]             stage;
    logic [3:0]             last_stage;
    logic [3:0]             s_nxt;
    logic [TW_WIDTH-1:0]    k;
    logic [TW_WIDTH-1:0]    k_last;
    logic [TW_WIDTH-1:0]    k_nxt;
    logic [OUT_WIDTH-1:0]   outstanding;
    logic                   load;
    logic                   accept;
    logic                   start_legal;
    logic                   drained;

    assign start_legal = size_legal(32'(fft_size), MAX_LOG2);
    assign accept      = bf.bf_valid && bf.bf_ready;
    assign drained     = (outstanding == '0);
    assign bf.bf_stage = stage;

    // Decide whether a new butterfly request is presented next cycle and which (stage, k) it is.
    always_comb begin
        load  = 1'b0;
        s_nxt = stage;
        k_nxt = k;
        case (state)
            ST_IDLE: begin
                if (fft_start && start_legal) begin
                    load  = 1'b1;
                    s_nxt = 4'd0;
                    k_nxt = '0;
                end
            end
            ST_ISSUE: begin
                if (accept && (k != k_last)) begin
                    load  = 1'b1;
                    k_nxt = k + TW_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (drained && (stage != last_stage)) begin
                    load  = 1'b1;
                    s_nxt = stage + 4'd1;
                    k_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    fft_bf_addr_gen #(
        .MAX_LOG2   (MAX_LOG2),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TW_WIDTH   (TW_WIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (load),
        .s      (s_nxt),
        .k      (k_nxt),
        .addr_a (bf.bf_addr_a),
        .addr_b (bf.bf_addr_b),
        .tw_idx (bf.bf_tw_idx)
    );

    // Main sequencing FSM: issue all butterflies of a stage, drain write-backs, advance or finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            size_err    <= 1'b0;
            fft_done    <= 1'b0;
            bf.bf_valid <= 1'b0;
            stage       <= 4'd0;
            last_stage  <= 4'd0;
            k           <= '0;
            k_last      <= '0;
        end else begin
            size_err <= 1'b0;
            fft_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fft_start) begin
                        if (start_legal) begin
                            state       <= ST_ISSUE;
                            busy        <= 1'b1;
                            bf.bf_valid <= 1'b1;
                            stage       <= 4'd0;
                            k           <= '0;
                            last_stage  <= 4'(size_log2(32'(fft_size)) - 1);
                            k_last      <= TW_WIDTH'(32'(fft_size >> 1) - 32'd1);
                        end else begin
                            size_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        if (k == k_last) begin
                            bf.bf_valid <= 1'b0;
                            state       <= ST_DRAIN;
                        end else begin
                            k <= k_nxt;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        if (stage != last_stage) begin
                            stage       <= s_nxt;
                            k           <= '0;
                            bf.bf_valid <= 1'b1;
                            state       <= ST_ISSUE;
                        end else begin
                            busy     <= 1'b0;
                            fft_done <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Butterflies accepted but not yet written back; stray write-backs at zero are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, bf.wb_valid && !drained})
                2'b10:   outstanding <= outstanding + OUT_WIDTH'(1);
                2'b01:   outstanding <= outstanding - OUT_WIDTH'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef FFT_SEQ_STALL_CNT_EN
    // Saturating count of cycles lost to datapath back-pressure or write-back draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if ((state == ST_IDLE) && fft_start && start_legal) begin
            stall_cycles <= 16'd0;
        end else if (((bf.bf_valid && !bf.bf_ready) || (state == ST_DRAIN)) &&
                     (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - scoreboard bench for the FFT stage sequencer
module tb_fft_stage_sequencer;

    logic        clk;
    logic        rst;
    logic        fft_start;
    logic [10:0] fft_size;
    logic        busy;
    logic        size_err;
    logic        fft_done;
`ifdef FFT_SEQ_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    fft_stage_sequencer_if #(.ADDR_WIDTH(5), .TW_WIDTH(4)) bf_if ();

    fft_stage_sequencer #(
        .MAX_LOG2   (5),
        .SIZE_WIDTH (11),
        .ADDR_WIDTH (5),
        .TW_WIDTH   (4),
        .OUT_WIDTH  (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fft_start    (fft_start),
        .fft_size     (fft_size),
        .busy         (busy),
        .size_err     (size_err),
        .fft_done     (fft_done),
        .bf           (bf_if)
`ifdef FFT_SEQ_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int tests = 0;
    int fails = 0;

    logic [17:0] sb[$];
    int          issue_cnt = 0;
    int          done_cnt  = 0;
    int          exp_stall = 0;
    int          model_out = 0;
    int          mode      = 0;
    int          stall_req = 0;
    logic        wb_extra  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected issue order built from the textbook group/offset loop nest.
    task automatic push_fft(input int n);
        int l;
        l = $clog2(n);
        for (int s = 0; s < l; s++) begin
            int half;
            half = 1 << s;
            for (int g = 0; g < n; g += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    sb.push_back({4'(s), 5'(g + j), 5'(g + j + half), 4'(j * (16 / half))});
                end
            end
        end
    endtask

    // Datapath model: drives bf_ready, returns write-backs 3 cycles after accept, checks issues.
    initial begin
        logic [2:0]  pipe;
        logic        prev_valid;
        logic        prev_stall;
        logic [17:0] prev_bus;
        logic [17:0] bus;
        logic        acc;
        logic        wb;
        pipe       = '0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        prev_bus   = '0;
        bf_if.bf_ready = 1'b0;
        bf_if.wb_valid = 1'b0;
        forever begin
            @(negedge clk);
            bus = {bf_if.bf_stage, bf_if.bf_addr_a, bf_if.bf_addr_b, bf_if.bf_tw_idx};
            if (rst) begin
                pipe = '0;
                model_out = 0;
                bf_if.bf_ready = 1'b0;
                bf_if.wb_valid = 1'b0;
                prev_valid = 1'b0;
                prev_stall = 1'b0;
                sb.delete();
            end else begin
                if (bf_if.bf_valid && !prev_valid && (bf_if.bf_stage != 4'd0))
                    chk("stage_start_after_drain", 64'(model_out), 64'd0);
                if (prev_stall)
                    chk("stall_hold", {bf_if.bf_valid, bus}, {1'b1, prev_bus});
                if (fft_done) begin
                    done_cnt++;
                    chk("busy_low_at_done", busy, 1'b0);
                end
                if (busy && !bf_if.bf_valid) exp_stall++;
                case (mode)
                    1: bf_if.bf_ready = ($urandom_range(0, 99) < 55);
                    2: begin
                        if (stall_req > 0 && bf_if.bf_valid) begin
                            bf_if.bf_ready = 1'b0;
                            stall_req--;
                        end else begin
                            bf_if.bf_ready = 1'b1;
                        end
                    end
                    default: bf_if.bf_ready = 1'b1;
                endcase
                acc = bf_if.bf_valid && bf_if.bf_ready;
                if (bf_if.bf_valid && !bf_if.bf_ready) exp_stall++;
                if (acc) begin
                    issue_cnt++;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        chk("bf_issue", bus, sb.pop_front());
                    end
                    if (bf_if.bf_stage == 4'd1 && bf_if.bf_addr_a == 5'd1)
                        chk("s1_k1", {bf_if.bf_addr_b, bf_if.bf_tw_idx}, {5'd3, 4'd8});
                    if (bf_if.bf_stage == 4'd4 && bf_if.bf_addr_a == 5'd5)
                        chk("s4_k5", {bf_if.bf_addr_b, bf_if.bf_tw_idx}, {5'd21, 4'd5});
                    if (bf_if.bf_stage == 4'd2 && bf_if.bf_addr_a == 5'd3)
                        chk("s2_k3", {bf_if.bf_addr_b, bf_if.bf_tw_idx}, {5'd7, 4'd12});
                end
                wb = pipe[2] | wb_extra;
                wb_extra = 1'b0;
                bf_if.wb_valid = wb;
                model_out = model_out + (acc ? 1 : 0) - ((wb && model_out > 0) ? 1 : 0);
                pipe = {pipe[1:0], acc};
                prev_valid = bf_if.bf_valid;
                prev_stall = bf_if.bf_valid && !bf_if.bf_ready;
                prev_bus   = bus;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_fft(input int n);
        push_fft(n);
        issue_cnt = 0;
        exp_stall = 0;
        fft_size  = 11'(n);
        fft_start = 1'b1;
        tick();
        fft_start = 1'b0;
        chk("start_busy_valid", {busy, bf_if.bf_valid, bf_if.bf_stage}, {1'b1, 1'b1, 4'd0});
    endtask

    task automatic wait_done(input int exp_issues);
        int d0;
        int c;
        d0 = done_cnt;
        c  = 0;
        while (done_cnt == d0 && c < 3000) begin
            tick();
            c++;
        end
        chk("done_seen", 64'(done_cnt - d0), 64'd1);
        repeat (3) tick();
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("issue_count", 64'(issue_cnt), 64'(exp_issues));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("idle_after_done", {busy, bf_if.bf_valid}, 2'b00);
    endtask

    task automatic illegal(input int n);
        logic seen;
        fft_size  = 11'(n);
        fft_start = 1'b1;
        tick();
        fft_start = 1'b0;
        chk("size_err_pulse", {size_err, busy, bf_if.bf_valid}, 3'b100);
        tick();
        chk("size_err_clear", size_err, 1'b0);
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen = seen | busy | bf_if.bf_valid;
        end
        chk("illegal_stays_idle", seen, 1'b0);
    endtask

    initial begin
        int c;
        rst       = 1'b1;
        fft_start = 1'b0;
        fft_size  = '0;
        repeat (3) tick();
        chk("reset_outputs",
            {busy, size_err, fft_done, bf_if.bf_valid, bf_if.bf_addr_a, bf_if.bf_addr_b,
             bf_if.bf_tw_idx, bf_if.bf_stage}, '0);
        rst = 1'b0;
        tick();

        wb_extra = 1'b1;
        tick();
        wb_extra = 1'b1;
        tick();

        mode = 0;
        start_fft(32);
        wait_done(80);
        start_fft(8);
        wait_done(12);
        start_fft(2);
        wait_done(1);

        mode = 1;
        start_fft(16);
        wait_done(32);
        start_fft(32);
        wait_done(80);

        illegal(24);
        illegal(64);
        illegal(1);

        start_fft(16);
        repeat (5) tick();
        fft_size  = 11'd8;
        fft_start = 1'b1;
        tick();
        fft_start = 1'b0;
        wait_done(32);

        mode = 0;
        start_fft(32);
        c = 0;
        while (bf_if.bf_stage != 4'd2 && c < 500) begin
            tick();
            c++;
        end
        chk("reach_stage2", bf_if.bf_stage, 4'd2);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_reset_outputs",
            {busy, size_err, fft_done, bf_if.bf_valid, bf_if.bf_addr_a, bf_if.bf_addr_b,
             bf_if.bf_tw_idx, bf_if.bf_stage}, '0);
        rst = 1'b0;
        tick();
        start_fft(32);
        wait_done(80);

`ifdef FFT_SEQ_STALL_CNT_EN
        mode      = 2;
        stall_req = 5;
        start_fft(32);
        wait_done(80);
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
        chk("stall_req_used", 64'(stall_req), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
